// File: rtl/ir_nec_receiver.sv
// ir_nec_receiver: NEC infrared frame decoder.
// Measures mark/space durations of a demodulated IR line in 10 us ticks and
// decodes NEC data frames (lead 9 ms / 4.5 ms, 32 bits LSB first, stop mark)
// and NEC repeat frames (lead 9 ms / 2.25 ms, stop mark).
// Ports:
//   clk          system clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   ir_in        raw demodulated IR line (async, low = carrier mark)
//   ir_data      last valid frame {byte1, byte0, inv_cmd, cmd}
//   data_ready   one-cycle pulse when ir_data updates
//   repeat_pulse one-cycle pulse on a valid repeat frame
//   frame_error  one-cycle pulse when a frame is aborted
module ir_nec_receiver #(
  parameter int TICK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_in,
  output logic [31:0] ir_data,
  output logic        data_ready,
  output logic        repeat_pulse,
  output logic        frame_error
);

  localparam int             PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [9:0]     CNT_MAX  = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, END_MARK
  } state_t;

  state_t        state;
  logic          s1, s2, prev;
  logic [PW-1:0] pre;
  logic [9:0]    cnt;
  logic [4:0]    bit_idx;
  logic [31:0]   shreg;
  logic          is_rep, rep_ok;
  logic          ev_data, ev_rep, ev_err;
  logic          tick, fall, rise, any_edge;

  function automatic logic in_win(input logic [9:0] v, input logic [9:0] lo,
                                  input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  assign fall     = prev & ~s2;
  assign rise     = ~prev & s2;
  assign any_edge = fall | rise;
  assign tick     = (pre == PRE_LAST);

  // Synchronizer plus edge-detect history; idle line level is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= ir_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + PW'(1);
  end

  // Interval length since the last edge, in ticks, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n)                     cnt <= '0;
    else if (any_edge)              cnt <= '0;
    else if (tick && cnt != CNT_MAX) cnt <= cnt + 10'd1;
  end

  // Each interval is classified on the edge that ends it, using the count
  // accumulated before that edge clears it. Completion events are staged in
  // ev_* and published one cycle later by the output register below.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      is_rep  <= 1'b0;
      rep_ok  <= 1'b0;
      ev_data <= 1'b0;
      ev_rep  <= 1'b0;
      ev_err  <= 1'b0;
    end else begin
      ev_data <= 1'b0;
      ev_rep  <= 1'b0;
      ev_err  <= 1'b0;
      // A saturated count means the line stuck mid-frame. Any edge seen at
      // saturation is out of every window, so it aborts here as well.
      if (state != IDLE && cnt == CNT_MAX) begin
        state  <= IDLE;
        ev_err <= 1'b1;
      end else begin
        case (state)
          IDLE: if (fall) state <= LEAD_MARK;
          LEAD_MARK: if (rise) begin
            if (in_win(cnt, 10'd800, 10'd1000)) state <= LEAD_SPACE;
            else begin state <= IDLE; ev_err <= 1'b1; end
          end
          LEAD_SPACE: if (fall) begin
            if (in_win(cnt, 10'd400, 10'd500)) begin
              state   <= BIT_MARK;
              bit_idx <= '0;
            end else if (in_win(cnt, 10'd190, 10'd260)) begin
              state  <= END_MARK;
              is_rep <= 1'b1;
            end else begin state <= IDLE; ev_err <= 1'b1; end
          end
          BIT_MARK: if (rise) begin
            if (in_win(cnt, 10'd36, 10'd76)) state <= BIT_SPACE;
            else begin state <= IDLE; ev_err <= 1'b1; end
          end
          BIT_SPACE: if (fall) begin
            if (in_win(cnt, 10'd36, 10'd76) || in_win(cnt, 10'd140, 10'd190)) begin
              // LSB first: after 32 shifts the first bit sits in shreg[0].
              shreg   <= {in_win(cnt, 10'd140, 10'd190), shreg[31:1]};
              bit_idx <= bit_idx + 5'd1;
              if (bit_idx == 5'd31) begin
                state  <= END_MARK;
                is_rep <= 1'b0;
              end else begin
                state <= BIT_MARK;
              end
            end else begin state <= IDLE; ev_err <= 1'b1; end
          end
          END_MARK: if (rise) begin
            state <= IDLE;
            if (!in_win(cnt, 10'd36, 10'd76))           ev_err <= 1'b1;
            else if (is_rep)                             begin
              if (rep_ok) ev_rep <= 1'b1;
              else        ev_err <= 1'b1;
            end else if (shreg[31:24] == ~shreg[23:16]) begin
              ev_data <= 1'b1;
              rep_ok  <= 1'b1;
            end else                                     ev_err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // shreg is stable here: it only shifts during the next frame's bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_data      <= '0;
      data_ready   <= 1'b0;
      repeat_pulse <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      data_ready   <= ev_data;
      repeat_pulse <= ev_rep;
      frame_error  <= ev_err;
      if (ev_data) ir_data <= {shreg[15:8], shreg[7:0], shreg[31:24], shreg[23:16]};
    end
  end

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Self-checking bench for ir_nec_receiver: randomized pulse durations inside
// the NEC windows, expected results from a frame-level model.
module tb_ir_nec_receiver;
  localparam int TK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ir_in = 1'b1;
  logic [31:0] ir_data;
  logic        data_ready, repeat_pulse, frame_error;

  int total = 0, bad = 0;
  int n_dr = 0, n_rp = 0, n_fe = 0, n_ovl = 0;
  logic [31:0] m_data = 32'h0;
  bit          m_rep_ok = 1'b0;

  ir_nec_receiver #(.TICK_CYCLES(TK)) dut (
    .clk(clk), .rst_n(rst_n), .ir_in(ir_in), .ir_data(ir_data),
    .data_ready(data_ready), .repeat_pulse(repeat_pulse), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_ready)   n_dr++;
    if (repeat_pulse) n_rp++;
    if (frame_error)  n_fe++;
    if (int'(data_ready) + int'(repeat_pulse) + int'(frame_error) > 1) n_ovl++;
  end

  // Frame-level model: outcome and new register value from the four bytes.
  function automatic void nec_model(input logic [7:0] b0, b1, b2, b3,
                                    output logic [2:0] kind, output logic [31:0] dat);
    if (b3 == ~b2) begin
      kind = 3'b100;
      dat  = {b1, b0, b3, b2};
    end else begin
      kind = 3'b001;
      dat  = m_data;
    end
  endfunction

  task automatic seg(input logic lvl, input int ticks);
    ir_in = lvl;
    repeat (ticks * TK) @(negedge clk);
  endtask

  // Releases the final mark and samples the pulse vector after E2, E3, E4
  // where E0 is the first edge that sees the line high.
  task automatic finish_rise(output logic [2:0] pre, output logic [2:0] at,
                             output logic [2:0] post, output logic [31:0] d_at);
    ir_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 pre = {data_ready, repeat_pulse, frame_error};
    @(posedge clk);
    #1 at = {data_ready, repeat_pulse, frame_error};
    d_at = ir_data;
    @(posedge clk);
    #1 post = {data_ready, repeat_pulse, frame_error};
    @(negedge clk);
  endtask

  task automatic send_head(input logic [31:0] w, input int nbits, input bit nom);
    seg(1'b1, 50);
    seg(1'b0, nom ? 900 : int'($urandom_range(802, 830)));
    seg(1'b1, nom ? 450 : int'($urandom_range(402, 420)));
    for (int i = 0; i < nbits; i++) begin
      seg(1'b0, nom ? 56 : int'($urandom_range(38, 45)));
      if (w[i]) seg(1'b1, nom ? 169 : int'($urandom_range(142, 150)));
      else      seg(1'b1, nom ? 56  : int'($urandom_range(38, 45)));
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, input bit nom,
                            output logic [2:0] pre, output logic [2:0] at,
                            output logic [2:0] post, output logic [31:0] d_at);
    send_head({b3, b2, b1, b0}, 32, nom);
    seg(1'b0, nom ? 56 : int'($urandom_range(38, 45)));
    finish_rise(pre, at, post, d_at);
  endtask

  task automatic send_repeat(output logic [2:0] pre, output logic [2:0] at,
                             output logic [2:0] post, output logic [31:0] d_at);
    seg(1'b1, 50);
    seg(1'b0, 900);
    seg(1'b1, 225);
    seg(1'b0, 56);
    finish_rise(pre, at, post, d_at);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ir_in = 1'b1;
    repeat (3) @(negedge clk);
    m_data = 32'h0; m_rep_ok = 1'b0;
    total++; if (ir_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", ir_data); end
    total++; if ({data_ready, repeat_pulse, frame_error} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses got=%b want=000", {data_ready, repeat_pulse, frame_error});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_repeat_no_data();
    logic [2:0] pre, at, post; logic [31:0] d;
    int dr0 = n_dr, rp0 = n_rp;
    send_repeat(pre, at, post, d);
    total++; if (at !== 3'b001) begin bad++; $display("FAIL rep_nodata_at got=%b want=001", at); end
    total++; if (n_dr - dr0 + n_rp - rp0 !== 0) begin
      bad++; $display("FAIL rep_nodata_pulses got=%0d want=0", n_dr - dr0 + n_rp - rp0);
    end
    total++; if (d !== m_data) begin bad++; $display("FAIL rep_nodata_data got=%h want=%h", d, m_data); end
  endtask

  task automatic test_valid_frame();
    logic [2:0] pre, at, post, kind; logic [31:0] d, md;
    nec_model(8'h00, 8'hFF, 8'h0C, 8'hF3, kind, md);
    send_frame(8'h00, 8'hFF, 8'h0C, 8'hF3, 1'b1, pre, at, post, d);
    total++; if (pre !== 3'b000) begin bad++; $display("FAIL valid_early got=%b want=000", pre); end
    total++; if (at !== kind) begin bad++; $display("FAIL valid_at got=%b want=%b", at, kind); end
    total++; if (post !== 3'b000) begin bad++; $display("FAIL valid_width got=%b want=000", post); end
    total++; if (d !== 32'hFF00_F30C) begin bad++; $display("FAIL valid_data got=%h want=ff00f30c", d); end
    m_data = md; m_rep_ok = 1'b1;
  endtask

  task automatic test_idle_hold();
    int fe0 = n_fe, dr0 = n_dr;
    seg(1'b1, 1100);
    total++; if (n_fe - fe0 + n_dr - dr0 !== 0) begin
      bad++; $display("FAIL idle_pulses got=%0d want=0", n_fe - fe0 + n_dr - dr0);
    end
    total++; if (ir_data !== m_data) begin bad++; $display("FAIL idle_data got=%h want=%h", ir_data, m_data); end
  endtask

  task automatic test_repeat();
    logic [2:0] pre, at, post; logic [31:0] d;
    send_repeat(pre, at, post, d);
    total++; if (pre !== 3'b000) begin bad++; $display("FAIL rep_early got=%b want=000", pre); end
    total++; if (at !== (m_rep_ok ? 3'b010 : 3'b001)) begin
      bad++; $display("FAIL rep_at got=%b want=%b", at, m_rep_ok ? 3'b010 : 3'b001);
    end
    total++; if (post !== 3'b000) begin bad++; $display("FAIL rep_width got=%b want=000", post); end
    total++; if (d !== m_data) begin bad++; $display("FAIL rep_data got=%h want=%h", d, m_data); end
  endtask

  task automatic test_bad_inverse();
    logic [2:0] pre, at, post, kind; logic [31:0] d, md;
    int dr0 = n_dr;
    nec_model(8'h00, 8'hFF, 8'h14, 8'h00, kind, md);
    send_frame(8'h00, 8'hFF, 8'h14, 8'h00, 1'b0, pre, at, post, d);
    total++; if (at !== kind) begin bad++; $display("FAIL badinv_at got=%b want=%b", at, kind); end
    total++; if (n_dr - dr0 !== 0) begin bad++; $display("FAIL badinv_ready got=%0d want=0", n_dr - dr0); end
    total++; if (d !== md) begin bad++; $display("FAIL badinv_data got=%h want=%h", d, md); end
  endtask

  task automatic test_errors();
    logic [2:0] pre, at, post, kind; logic [31:0] d, md;
    logic [7:0] a;
    int fe0;
    fe0 = n_fe;
    seg(1'b1, 50); seg(1'b0, 700); seg(1'b1, 100);
    total++; if (n_fe - fe0 !== 1) begin bad++; $display("FAIL err_lead got=%0d want=1", n_fe - fe0); end
    fe0 = n_fe;
    seg(1'b0, 850); seg(1'b1, 430); seg(1'b0, 50); seg(1'b1, 100);
    seg(1'b0, 50); seg(1'b1, 100);
    total++; if (n_fe - fe0 !== 1) begin bad++; $display("FAIL err_space got=%0d want=1", n_fe - fe0); end
    fe0 = n_fe;
    seg(1'b0, 1100); seg(1'b1, 100);
    total++; if (n_fe - fe0 !== 1) begin bad++; $display("FAIL err_stuck got=%0d want=1", n_fe - fe0); end
    a = 8'($urandom);
    nec_model(a, ~a, 8'h18, 8'hE7, kind, md);
    send_frame(a, ~a, 8'h18, 8'hE7, 1'b0, pre, at, post, d);
    total++; if (at !== kind) begin bad++; $display("FAIL err_recover_at got=%b want=%b", at, kind); end
    total++; if (d !== md) begin bad++; $display("FAIL err_recover_data got=%h want=%h", d, md); end
    m_data = md; m_rep_ok = 1'b1;
  endtask

  task automatic test_reset_midframe();
    logic [2:0] pre, at, post, kind; logic [31:0] d, md;
    logic [7:0] a;
    int p0 = n_dr + n_rp + n_fe;
    send_head($urandom, 20, 1'b0);
    seg(1'b0, 20);
    rst_n = 1'b0;
    ir_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_data = 32'h0; m_rep_ok = 1'b0;
    seg(1'b1, 100);
    total++; if (n_dr + n_rp + n_fe - p0 !== 0) begin
      bad++; $display("FAIL midrst_pulses got=%0d want=0", n_dr + n_rp + n_fe - p0);
    end
    total++; if (ir_data !== m_data) begin bad++; $display("FAIL midrst_data got=%h want=%h", ir_data, m_data); end
    a = 8'($urandom);
    nec_model(a, 8'($urandom), 8'h1B, 8'hE4, kind, md);
    send_frame(md[23:16], md[31:24], 8'h1B, 8'hE4, 1'b0, pre, at, post, d);
    total++; if (at !== 3'b100) begin bad++; $display("FAIL midrst_next_at got=%b want=100", at); end
    total++; if (d !== md) begin bad++; $display("FAIL midrst_next_data got=%h want=%h", d, md); end
    total++; if (d[7:0] !== 8'h1B) begin bad++; $display("FAIL midrst_next_cmd got=%h want=1b", d[7:0]); end
    m_data = md; m_rep_ok = 1'b1;
  endtask

  task automatic test_exclusive();
    total++; if (n_ovl !== 0) begin bad++; $display("FAIL pulse_overlap got=%0d want=0", n_ovl); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_repeat_no_data();
    test_valid_frame();
    test_idle_hold();
    test_repeat();
    test_bad_inverse();
    test_errors();
    test_reset_midframe();
    test_repeat();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
